projectile_flight_ctrl: RTL and testbench



---
 rtl/wwm_pkg.sv | 24 ++
 rtl/tick_divider.sv | 33 +++
 rtl/projectile_flight_ctrl.sv | 169 ++++++++++++++++
 tb/tb_projectile_flight_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wwm_pkg.sv
// Shared World War Math definitions: flight FSM encoding, screen geometry and colours.
package wwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ANIMATE = 2'd1,
        ST_HIT     = 2'd2,
        ST_MISS    = 2'd3
    } flight_state_e;

    localparam int GROUND_Y     = 470;
    localparam int TOP_Y        = 51;
    localparam int RIGHT_X      = 774;
    localparam int TGT_XL       = 650;
    localparam int TGT_XR       = 675;
    localparam int SCREEN_X_MAX = 1023;

    // 12-bit RGB (4:4:4) as consumed by vga_bitchange
    localparam logic [11:0] COL_PROJECTILE = 12'hFFF;
    localparam logic [11:0] COL_TARGET     = 12'hF00;
    localparam logic [11:0] COL_GROUND     = 12'h0A0;
    localparam logic [11:0] COL_SKY        = 12'h49F;

endpackage

// File: rtl/tick_divider.sv
// Free-running step divider: pulses tick once every TICK_CLKS clocks while en is high.
module tick_divider #(
    parameter int TICK_CLKS = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == CW'(TICK_CLKS - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/projectile_flight_ctrl.sv
// One cannon shot: latch launch conditions, step kinematics on a divided tick,
// classify hit / ground miss / off-screen miss and hold the result until ack.
module projectile_flight_ctrl
    import wwm_pkg::*;
#(
    parameter int          TICK_CLKS = 50_000_000,
    parameter logic [3:0]  GRAV      = 4'd1,
    parameter int          MAX_T     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ack,
    input  logic [3:0] vX,
    input  logic [3:0] vY,
    input  logic [9:0] X_INITIAL,
    input  logic [9:0] Y_INITIAL,
    output logic [9:0] projectileCenterX,
    output logic [9:0] projectileCenterY,
    output logic [7:0] t_air,
    output logic       q_Idle,
    output logic       q_Animate,
    output logic       q_Hit,
    output logic       q_Miss,
    output logic       done
);

    localparam logic signed [21:0] GROUND_S = 22'(GROUND_Y);
    localparam logic signed [21:0] TOP_S    = 22'(TOP_Y);
    localparam logic signed [21:0] RIGHT_S  = 22'(RIGHT_X);
    localparam logic signed [21:0] TGT_XL_S = 22'(TGT_XL);
    localparam logic signed [21:0] TGT_XR_S = 22'(TGT_XR);
    localparam logic signed [21:0] XMAX_S   = 22'(SCREEN_X_MAX);

    flight_state_e state_q, state_d;
    logic [3:0] vx_q, vx_d, vy_q, vy_d;
    logic [9:0] x0_q, x0_d, y0_q, y0_d;
    logic [9:0] cx_q, cx_d, cy_q, cy_d;
    logic [7:0] t_air_q, t_air_d;
    logic       done_q, done_d;

    logic tick;

    tick_divider #(
        .TICK_CLKS(TICK_CLKS)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .en   (state_q == ST_ANIMATE),
        .tick (tick)
    );

    // Kinematics are evaluated for the step about to fire (t = t_air + 1).
    logic [7:0]        t_next;
    logic signed [21:0] t_w, vx_w, vy_w, g_w, x0_w, y0_w;
    logic signed [21:0] x_calc, y_calc;
    logic              landed, in_target, off_right, t_limit;
    logic [9:0]        x_disp, y_disp;

    assign t_next = t_air_q + 8'd1;
    assign t_w    = signed'({14'd0, t_next});
    assign vx_w   = signed'({18'd0, vx_q});
    assign vy_w   = signed'({18'd0, vy_q});
    assign g_w    = signed'({18'd0, GRAV});
    assign x0_w   = signed'({12'd0, x0_q});
    assign y0_w   = signed'({12'd0, y0_q});

    // Gravity term is never negative, so the arithmetic shift is a floor divide.
    assign x_calc = x0_w + vx_w * t_w;
    assign y_calc = y0_w - vy_w * t_w + ((g_w * t_w * t_w) >>> 1);

    assign landed    = (y_calc >= GROUND_S);
    assign in_target = (x_calc >= TGT_XL_S) && (x_calc <= TGT_XR_S);
    assign off_right = (x_calc > RIGHT_S);
    assign t_limit   = (t_next == 8'(MAX_T));

    always_comb begin
        x_disp = x_calc[9:0];
        if (x_calc > XMAX_S) begin
            x_disp = 10'(SCREEN_X_MAX);
        end
        y_disp = y_calc[9:0];
        if (landed) begin
            y_disp = 10'(GROUND_Y);
        end else if (y_calc < TOP_S) begin
            y_disp = 10'(TOP_Y);
        end
    end

    always_comb begin
        state_d = state_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        t_air_d = t_air_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cx_d = X_INITIAL;
                cy_d = Y_INITIAL;
                if (start) begin
                    vx_d    = vX;
                    vy_d    = vY;
                    x0_d    = X_INITIAL;
                    y0_d    = Y_INITIAL;
                    t_air_d = '0;
                    state_d = ST_ANIMATE;
                end
            end
            ST_ANIMATE: begin
                if (tick) begin
                    cx_d    = x_disp;
                    cy_d    = y_disp;
                    t_air_d = t_next;
                    if (landed && in_target) begin
                        state_d = ST_HIT;
                        done_d  = 1'b1;
                    end else if (landed || off_right || t_limit) begin
                        state_d = ST_MISS;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_HIT, ST_MISS: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            vx_q    <= '0;
            vy_q    <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            t_air_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            t_air_q <= t_air_d;
            done_q  <= done_d;
        end
    end

    assign projectileCenterX = cx_q;
    assign projectileCenterY = cy_q;
    assign t_air             = t_air_q;
    assign done              = done_q;
    assign q_Idle            = (state_q == ST_IDLE);
    assign q_Animate         = (state_q == ST_ANIMATE);
    assign q_Hit             = (state_q == ST_HIT);
    assign q_Miss            = (state_q == ST_MISS);

endmodule

// File: tb/tb_projectile_flight_ctrl.sv
// Directed bench for projectile_flight_ctrl with TICK_CLKS=4, GRAV=1.
module tb_projectile_flight_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] vX = 4'd0;
    logic [3:0] vY = 4'd0;
    logic [9:0] X_INITIAL = 10'd0;
    logic [9:0] Y_INITIAL = 10'd0;
    logic [9:0] px, py;
    logic [7:0] t_air;
    logic       q_Idle, q_Animate, q_Hit, q_Miss, done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    projectile_flight_ctrl #(
        .TICK_CLKS(4),
        .GRAV     (4'd1),
        .MAX_T    (255)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .ack              (ack),
        .vX               (vX),
        .vY               (vY),
        .X_INITIAL        (X_INITIAL),
        .Y_INITIAL        (Y_INITIAL),
        .projectileCenterX(px),
        .projectileCenterY(py),
        .t_air            (t_air),
        .q_Idle           (q_Idle),
        .q_Animate        (q_Animate),
        .q_Hit            (q_Hit),
        .q_Miss           (q_Miss),
        .done             (done)
    );

    // Advance n clock edges; inputs change and outputs are sampled 1ns after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int maxc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            step(1);
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_t(input logic [7:0] want, input int maxc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            step(1);
            if (t_air === want) seen = 1'b1;
        end
    endtask

    task automatic fire(input logic [9:0] x0, input logic [9:0] y0,
                        input logic [3:0] vx, input logic [3:0] vy);
        X_INITIAL = x0;
        Y_INITIAL = y0;
        vX = vx;
        vY = vy;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        X_INITIAL = 10'd200;
        Y_INITIAL = 10'd465;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        total++; if ({q_Idle, q_Animate, q_Hit, q_Miss} !== 4'b1000) begin bad++; $display("FAIL reset_flags got=%b want=1000", {q_Idle, q_Animate, q_Hit, q_Miss}); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (t_air !== 8'd0) begin bad++; $display("FAIL reset_tair got=%0d want=0", t_air); end
        total++; if (px !== 10'd0 || py !== 10'd0) begin bad++; $display("FAIL reset_xy got=%0d,%0d want=0,0", px, py); end
        step(1);
        total++; if (px !== 10'd200 || py !== 10'd465) begin bad++; $display("FAIL idle_track got=%0d,%0d want=200,465", px, py); end
        $display("reset: flags=%b t_air=%0d X=%0d Y=%0d", {q_Idle, q_Animate, q_Hit, q_Miss}, t_air, px, py);
    endtask

    task automatic test_hit();
        bit seen;
        fire(10'd200, 10'd465, 4'd15, 4'd15);
        total++; if (q_Animate !== 1'b1 || t_air !== 8'd0) begin bad++; $display("FAIL hit_enter got=anim%b t%0d want=anim1 t0", q_Animate, t_air); end
        // Launch inputs change mid-flight and must be ignored.
        vX = 4'd1; vY = 4'd2; X_INITIAL = 10'd10; Y_INITIAL = 10'd20;
        step(3);
        total++; if (t_air !== 8'd0) begin bad++; $display("FAIL hit_early_step got=%0d want=0", t_air); end
        step(1);
        total++; if (t_air !== 8'd1 || px !== 10'd215 || py !== 10'd450) begin bad++; $display("FAIL hit_t1 got=t%0d (%0d,%0d) want=t1 (215,450)", t_air, px, py); end
        wait_t(8'd30, 200, seen);
        total++; if (!seen) begin bad++; $display("FAIL hit_wait_t30 got=timeout want=t_air 30"); end
        total++; if (px !== 10'd650 || py !== 10'd465 || q_Animate !== 1'b1) begin bad++; $display("FAIL hit_t30 got=(%0d,%0d) anim%b want=(650,465) anim1", px, py, q_Animate); end
        step(4);
        total++; if (q_Hit !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL hit_state got=hit%b done%b want=hit1 done1", q_Hit, done); end
        total++; if (px !== 10'd665 || py !== 10'd470 || t_air !== 8'd31) begin bad++; $display("FAIL hit_final got=(%0d,%0d) t%0d want=(665,470) t31", px, py, t_air); end
        step(1);
        total++; if (done !== 1'b0 || q_Hit !== 1'b1 || px !== 10'd665 || py !== 10'd470) begin bad++; $display("FAIL hit_hold got=done%b hit%b (%0d,%0d) want=done0 hit1 (665,470)", done, q_Hit, px, py); end
        $display("shot hit: X=%0d Y=%0d t_air=%0d", px, py, t_air);
        do_ack();
        total++; if (q_Idle !== 1'b1) begin bad++; $display("FAIL hit_ack got=idle%b want=1", q_Idle); end
    endtask

    task automatic test_ground_miss();
        bit seen;
        fire(10'd200, 10'd465, 4'd5, 4'd15);
        wait_done(200, seen);
        total++; if (!seen) begin bad++; $display("FAIL gmiss_timeout got=no done want=done"); end
        total++; if (q_Miss !== 1'b1 || t_air !== 8'd31 || px !== 10'd355 || py !== 10'd470) begin bad++; $display("FAIL gmiss_final got=miss%b t%0d (%0d,%0d) want=miss1 t31 (355,470)", q_Miss, t_air, px, py); end
        $display("shot ground miss: X=%0d Y=%0d t_air=%0d", px, py, t_air);
        // start in MISS without ack is ignored
        start = 1'b1;
        step(2);
        start = 1'b0;
        total++; if (q_Miss !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL gmiss_start_ignored got=miss%b done%b want=miss1 done0", q_Miss, done); end
        // ack and start together: ack wins, start is dropped
        ack = 1'b1; start = 1'b1;
        step(1);
        ack = 1'b0; start = 1'b0;
        total++; if (q_Idle !== 1'b1) begin bad++; $display("FAIL gmiss_ack got=idle%b want=1", q_Idle); end
        step(1);
        total++; if (q_Idle !== 1'b1) begin bad++; $display("FAIL ack_start_dropped got=idle%b anim%b want=idle1", q_Idle, q_Animate); end
    endtask

    task automatic test_right_miss();
        bit seen;
        fire(10'd700, 10'd465, 4'd15, 4'd15);
        step(6);
        start = 1'b1; ack = 1'b1;
        step(1);
        start = 1'b0; ack = 1'b0;
        total++; if (q_Animate !== 1'b1 || t_air !== 8'd1) begin bad++; $display("FAIL rmiss_midflight got=anim%b t%0d want=anim1 t1", q_Animate, t_air); end
        wait_done(100, seen);
        total++; if (!seen) begin bad++; $display("FAIL rmiss_timeout got=no done want=done"); end
        total++; if (q_Miss !== 1'b1 || t_air !== 8'd5 || px !== 10'd775 || py !== 10'd402) begin bad++; $display("FAIL rmiss_final got=miss%b t%0d (%0d,%0d) want=miss1 t5 (775,402)", q_Miss, t_air, px, py); end
        $display("shot right miss: X=%0d Y=%0d t_air=%0d", px, py, t_air);
        do_ack();
    endtask

    task automatic test_vx_zero();
        bit seen;
        fire(10'd300, 10'd465, 4'd0, 4'd15);
        wait_done(200, seen);
        total++; if (!seen) begin bad++; $display("FAIL vx0_timeout got=no done want=done"); end
        total++; if (q_Miss !== 1'b1 || t_air !== 8'd31 || px !== 10'd300 || py !== 10'd470) begin bad++; $display("FAIL vx0_final got=miss%b t%0d (%0d,%0d) want=miss1 t31 (300,470)", q_Miss, t_air, px, py); end
        $display("shot vx=0: X=%0d Y=%0d t_air=%0d", px, py, t_air);
        do_ack();
    endtask

    task automatic test_clamp_and_reset();
        bit seen;
        bit done_seen;
        fire(10'd100, 10'd100, 4'd1, 4'd15);
        wait_t(8'd3, 40, seen);
        total++; if (!seen || py !== 10'd59 || px !== 10'd103) begin bad++; $display("FAIL clamp_t3 got=(%0d,%0d) want=(103,59)", px, py); end
        wait_t(8'd4, 40, seen);
        total++; if (!seen || py !== 10'd51 || px !== 10'd104 || q_Animate !== 1'b1) begin bad++; $display("FAIL clamp_t4 got=(%0d,%0d) anim%b want=(104,51) anim1", px, py, q_Animate); end
        wait_t(8'd10, 60, seen);
        total++; if (!seen || py !== 10'd51 || px !== 10'd110) begin bad++; $display("FAIL clamp_t10 got=(%0d,%0d) want=(110,51)", px, py); end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        total++; if (q_Idle !== 1'b1 || q_Animate !== 1'b0 || t_air !== 8'd0 || done !== 1'b0 || px !== 10'd0 || py !== 10'd0) begin bad++; $display("FAIL midflight_reset got=idle%b t%0d done%b (%0d,%0d) want=idle1 t0 done0 (0,0)", q_Idle, t_air, done, px, py); end
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (done === 1'b1) done_seen = 1'b1;
        end
        total++; if (done_seen || q_Idle !== 1'b1) begin bad++; $display("FAIL post_reset_quiet got=done_seen%b idle%b want=0,1", done_seen, q_Idle); end
        $display("shot reset mid-flight: idle=%b t_air=%0d", q_Idle, t_air);
    endtask

    initial begin
        step(1);
        test_reset();
        test_hit();
        test_ground_miss();
        test_right_miss();
        test_vx_zero();
        test_clamp_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
